// File: rtl/cache_pkg.sv
// Shared constants and types for the cache line refill controller.
package cache_pkg;

    localparam int DATA       = 32;
    localparam int TAG        = 27;
    localparam int WORD_OFS_W = 2;
    localparam int IDX_W      = 2;
    localparam int LINE_OFS_W = WORD_OFS_W + IDX_W;
    localparam int WORDS      = 4;
    localparam int CNT_W      = 3;

    localparam logic [DATA-1:0] LINE_MASK = ~DATA'((1 << LINE_OFS_W) - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FILL
    } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Main-memory read port of the refill controller: request/accept, then data/valid.
interface cache_refill_ctrl_if #(
    parameter int DATA = cache_pkg::DATA
);
    logic            mem_req_o;
    logic [DATA-1:0] mem_addr_o;
    logic            mem_ready_i;
    logic            mem_valid_i;
    logic [DATA-1:0] mem_data_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_ready_i,
        input  mem_valid_i,
        input  mem_data_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ready_i,
        output mem_valid_i,
        output mem_data_i
    );
endinterface

// File: rtl/refill_line_buf.sv
// Four-word capture buffer; each returning word is written into the slot of its address.
module refill_line_buf
    import cache_pkg::*;
#(
    parameter int DATA = cache_pkg::DATA
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [IDX_W-1:0]            idx,
    input  logic [DATA-1:0]             din,
    output logic [WORDS-1:0][DATA-1:0]  words
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words <= '0;
        end else if (we) begin
            words[idx] <= din;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache line refill FSM: fetches four words from memory and presents the full line.
// Build option REFILL_CRITICAL_WORD_FIRST_EN starts the fetch at the missing word.
module cache_refill_ctrl #(
    parameter int DATA = cache_pkg::DATA,
    parameter int TAG  = cache_pkg::TAG
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       miss_i,
    input  logic [DATA-1:0]            addr_i,
    cache_refill_ctrl_if.master        mem,
    output logic                       fill_valid_o,
    output logic [DATA-1:0]            fill_addr_o,
    output logic [DATA-1:0]            fill_word0_o,
    output logic [DATA-1:0]            fill_word1_o,
    output logic [DATA-1:0]            fill_word2_o,
    output logic [DATA-1:0]            fill_word3_o,
    output logic                       stall_o
);
    import cache_pkg::*;

    refill_state_t               state;
    logic [DATA-1:0]             line_addr;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            next_idx;
    logic [IDX_W-1:0]            start_idx;
    logic [CNT_W-1:0]            count;
    logic                        capture;
    logic                        last_word;
    logic                        mem_req;
    logic [DATA-1:0]             mem_addr;
    logic [WORDS-1:0][DATA-1:0]  line_words;
    logic [WORDS-1:0][DATA-1:0]  fill_next;
    logic [WORDS-1:0][DATA-1:0]  fill_words;
    logic [TAG-1:0]              unused_tag;
    logic                        unused_ofs;

    function automatic logic [DATA-1:0] word_addr(input logic [DATA-LINE_OFS_W-1:0] line,
                                                  input logic [IDX_W-1:0] i);
        return {line, i, WORD_OFS_W'(0)};
    endfunction

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    assign start_idx = addr_i[LINE_OFS_W-1:WORD_OFS_W];
`else
    assign start_idx = '0;
`endif

    assign unused_ofs = ^addr_i[LINE_OFS_W-1:0];
    assign unused_tag = addr_i[DATA-1:DATA-TAG];

    assign next_idx  = idx + 1'b1;
    assign capture   = (state == WAIT && mem.mem_valid_i) ||
                       (state == REQ && mem.mem_ready_i && mem.mem_valid_i);
    assign last_word = (count == CNT_W'(WORDS - 1));
    assign stall_o   = (state != IDLE) || (state == IDLE && miss_i);

    // The final word is captured on the same edge the line is published, so merge it in.
    always_comb begin
        fill_next = line_words;
        for (int k = 0; k < WORDS; k++) begin
            if (capture && idx == IDX_W'(k)) begin
                fill_next[k] = mem.mem_data_i;
            end
        end
    end

    refill_line_buf #(.DATA(DATA)) u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (capture),
        .idx   (idx),
        .din   (mem.mem_data_i),
        .words (line_words)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            idx          <= '0;
            line_addr    <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            fill_valid_o <= 1'b0;
            fill_addr_o  <= '0;
            fill_words   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_i) begin
                        line_addr <= {addr_i[DATA-1:LINE_OFS_W], LINE_OFS_W'(0)};
                        idx       <= start_idx;
                        count     <= '0;
                        mem_req   <= 1'b1;
                        mem_addr  <= word_addr(addr_i[DATA-1:LINE_OFS_W], start_idx);
                        state     <= REQ;
                    end
                end
                REQ, WAIT: begin
                    if (capture) begin
                        count <= count + 1'b1;
                        if (last_word) begin
                            mem_req      <= 1'b0;
                            fill_valid_o <= 1'b1;
                            fill_addr_o  <= line_addr;
                            fill_words   <= fill_next;
                            state        <= FILL;
                        end else begin
                            idx      <= next_idx;
                            mem_req  <= 1'b1;
                            mem_addr <= word_addr(line_addr[DATA-1:LINE_OFS_W], next_idx);
                            state    <= REQ;
                        end
                    end else if (state == REQ && mem.mem_ready_i) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                FILL: begin
                    fill_valid_o <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem.mem_req_o  = mem_req;
    assign mem.mem_addr_o = mem_addr;
    assign fill_word0_o   = fill_words[0];
    assign fill_word1_o   = fill_words[1];
    assign fill_word2_o   = fill_words[2];
    assign fill_word3_o   = fill_words[3];

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a scripted memory responder.
module tb_cache_refill_ctrl;

    localparam int DW         = 32;
    localparam int MODE_MAN   = 0;
    localparam int MODE_SAME  = 1;
    localparam int MODE_DELAY = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_i;
    logic [DW-1:0] addr_i;
    logic          fill_valid;
    logic [DW-1:0] fill_addr;
    logic [DW-1:0] fw0, fw1, fw2, fw3;
    logic          stall;

    cache_refill_ctrl_if #(.DATA(DW)) mem_bus ();

    cache_refill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .miss_i       (miss_i),
        .addr_i       (addr_i),
        .mem          (mem_bus),
        .fill_valid_o (fill_valid),
        .fill_addr_o  (fill_addr),
        .fill_word0_o (fw0),
        .fill_word1_o (fw1),
        .fill_word2_o (fw2),
        .fill_word3_o (fw3),
        .stall_o      (stall)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            mode = MODE_MAN;
    logic          man_ready = 1'b0;
    logic          man_valid = 1'b0;
    logic [31:0]   man_data = '0;
    logic [15:0]   pat_hi = '0;
    int            hold_at = -1;
    int            hold_len = 0;
    int            hold_done = 0;
    logic          prev_req = 1'b0;
    logic          prev_ready = 1'b0;
    logic [31:0]   prev_addr = '0;
    logic          rsp_ready, rsp_valid;
    logic [31:0]   rsp_data;
    logic [31:0]   acc_log [64];
    logic [31:0]   hold_log [64];
    int            acc_cnt = 0;
    int            hold_cnt = 0;
    int            wait_cnt = 0;
    int            fill_cnt = 0;
    logic [31:0]   exp_ord [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {pat_hi, a[15:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: accepted requests, refused requests, WAIT-like cycles and fill pulses.
    always @(posedge clk) begin
        if (mem_bus.mem_req_o && mem_bus.mem_ready_i) begin
            acc_log[acc_cnt % 64] <= mem_bus.mem_addr_o;
            acc_cnt <= acc_cnt + 1;
        end
        if (mem_bus.mem_req_o && !mem_bus.mem_ready_i) begin
            hold_log[hold_cnt % 64] <= mem_bus.mem_addr_o;
            hold_cnt <= hold_cnt + 1;
        end
        if (stall && !mem_bus.mem_req_o && !fill_valid && !miss_i) wait_cnt <= wait_cnt + 1;
        if (fill_valid) fill_cnt <= fill_cnt + 1;
    end

    // Memory model, driven shortly after each rising edge from the settled DUT outputs.
    always @(posedge clk) begin
        #2;
        case (mode)
            MODE_SAME: begin
                rsp_ready = 1'b1;
                rsp_valid = mem_bus.mem_req_o;
                rsp_data  = pat(mem_bus.mem_addr_o);
            end
            MODE_DELAY: begin
                rsp_valid = prev_req && prev_ready;
                rsp_data  = pat(prev_addr);
                rsp_ready = 1'b1;
                if (mem_bus.mem_req_o && acc_cnt == hold_at && hold_done < hold_len) begin
                    rsp_ready = 1'b0;
                    hold_done++;
                end
            end
            default: begin
                rsp_ready = man_ready;
                rsp_valid = man_valid;
                rsp_data  = man_data;
            end
        endcase
        prev_req   = mem_bus.mem_req_o;
        prev_ready = rsp_ready;
        prev_addr  = mem_bus.mem_addr_o;
        mem_bus.mem_ready_i = rsp_ready;
        mem_bus.mem_valid_i = rsp_valid;
        mem_bus.mem_data_i  = rsp_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_miss(input logic [31:0] a, output int t0);
        tick();
        miss_i = 1'b1;
        addr_i = a;
        t0 = cyc;
        @(negedge clk);
        check_eq("stall_on_miss", {31'b0, stall}, 32'd1);
        tick();
        miss_i = 1'b0;
        addr_i = '0;
        check_eq("stall_busy", {31'b0, stall}, 32'd1);
    endtask

    task automatic wait_fill(input string tag, input int t0, input int exp_lat);
        int lat;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fill_valid) begin
                lat = cyc - t0;
                break;
            end
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic check_fill(input string tag, input logic [31:0] a, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
        check_eq({tag, "_addr"}, fill_addr, a);
        check_eq({tag, "_w0"}, fw0, w0);
        check_eq({tag, "_w1"}, fw1, w1);
        check_eq({tag, "_w2"}, fw2, w2);
        check_eq({tag, "_w3"}, fw3, w3);
        @(negedge clk);
        check_eq({tag, "_pulse_end"}, {31'b0, fill_valid}, 32'd0);
        check_eq({tag, "_stall_end"}, {31'b0, stall}, 32'd0);
    endtask

    initial begin
        int t0, b_acc, b_wait, b_hold, b_fill;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
        exp_ord = '{32'h48, 32'h4C, 32'h40, 32'h44};
`else
        exp_ord = '{32'h40, 32'h44, 32'h48, 32'h4C};
`endif
        rst = 1'b1;
        miss_i = 1'b0;
        addr_i = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_mem_req", {31'b0, mem_bus.mem_req_o}, 32'd0);
        check_eq("rst_mem_addr", mem_bus.mem_addr_o, 32'd0);
        check_eq("rst_fill_valid", {31'b0, fill_valid}, 32'd0);
        check_eq("rst_stall", {31'b0, stall}, 32'd0);
        check_eq("rst_fill_addr", fill_addr, 32'd0);
        check_eq("rst_fw0", fw0, 32'd0);
        tick();
        rst = 1'b0;

        // Ready always high, data one cycle after accept.
        mode = MODE_DELAY;
        pat_hi = 16'h1111;
        b_acc = acc_cnt;
        b_wait = wait_cnt;
        start_miss(32'h0000_0048, t0);
        wait_fill("seq", t0, 9);
        check_fill("seq", 32'h40, 32'h1111_0040, 32'h1111_0044, 32'h1111_0048, 32'h1111_004C);
        for (int i = 0; i < 4; i++) check_eq($sformatf("seq_req%0d", i), acc_log[b_acc + i], exp_ord[i]);
        check_eq("seq_nreq", acc_cnt - b_acc, 4);
        check_eq("seq_wait_cycles", wait_cnt - b_wait, 4);

        // Same-cycle accept and data.
        mode = MODE_SAME;
        pat_hi = 16'h2222;
        b_wait = wait_cnt;
        start_miss(32'h1234_5678, t0);
        wait_fill("same", t0, 5);
        check_fill("same", 32'h1234_5670, 32'h2222_5670, 32'h2222_5674, 32'h2222_5678, 32'h2222_567C);
        check_eq("same_wait_cycles", wait_cnt - b_wait, 0);

        // Spurious valid while idle.
        mode = MODE_MAN;
        man_ready = 1'b1;
        man_valid = 1'b1;
        man_data = 32'hDEAD_BEEF;
        b_fill = fill_cnt;
        repeat (3) tick();
        man_valid = 1'b0;
        @(negedge clk);
        check_eq("spur_w0", fw0, 32'h2222_5670);
        check_eq("spur_w1", fw1, 32'h2222_5674);
        check_eq("spur_w2", fw2, 32'h2222_5678);
        check_eq("spur_w3", fw3, 32'h2222_567C);
        check_eq("spur_req", {31'b0, mem_bus.mem_req_o}, 32'd0);
        check_eq("spur_fills", fill_cnt - b_fill, 0);

        // Memory refuses word 1 for three cycles.
        mode = MODE_DELAY;
        pat_hi = 16'h3333;
        b_acc = acc_cnt;
        b_hold = hold_cnt;
        hold_at = acc_cnt + 1;
        hold_len = 3;
        start_miss(32'h0000_0080, t0);
        wait_fill("hold", t0, 12);
        check_fill("hold", 32'h80, 32'h3333_0080, 32'h3333_0084, 32'h3333_0088, 32'h3333_008C);
        check_eq("hold_refused", hold_cnt - b_hold, 3);
        for (int i = 0; i < 3; i++) check_eq($sformatf("hold_addr%0d", i), hold_log[b_hold + i], 32'h84);
        check_eq("hold_nreq", acc_cnt - b_acc, 4);
        check_eq("hold_req1", acc_log[b_acc + 1], 32'h84);

        // Second miss during WAIT is ignored.
        pat_hi = 16'h4444;
        b_acc = acc_cnt;
        start_miss(32'h0000_0100, t0);
        tick();
        miss_i = 1'b1;
        addr_i = 32'h0000_0200;
        tick();
        miss_i = 1'b0;
        addr_i = '0;
        wait_fill("remiss", t0, 9);
        check_fill("remiss", 32'h100, 32'h4444_0100, 32'h4444_0104, 32'h4444_0108, 32'h4444_010C);
        check_eq("remiss_nreq", acc_cnt - b_acc, 4);
        check_eq("remiss_last_req", acc_log[b_acc + 3], 32'h10C);

        // Reset in WAIT after two captures, then late data.
        mode = MODE_MAN;
        man_ready = 1'b1;
        man_valid = 1'b0;
        b_fill = fill_cnt;
        start_miss(32'h0000_0140, t0);
        tick();
        man_valid = 1'b1;
        man_data = 32'h5555_0140;
        tick();
        man_valid = 1'b0;
        tick();
        man_valid = 1'b1;
        man_data = 32'h5555_0144;
        tick();
        man_valid = 1'b0;
        tick();
        check_eq("mid_in_wait", {31'b0, stall & ~mem_bus.mem_req_o}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_req", {31'b0, mem_bus.mem_req_o}, 32'd0);
        check_eq("mid_rst_addr", mem_bus.mem_addr_o, 32'd0);
        check_eq("mid_rst_stall", {31'b0, stall}, 32'd0);
        check_eq("mid_rst_fill_addr", fill_addr, 32'd0);
        check_eq("mid_rst_fw0", fw0, 32'd0);
        check_eq("mid_rst_fw3", fw3, 32'd0);
        tick();
        rst = 1'b0;
        man_valid = 1'b1;
        man_data = 32'hBAD0_BAD0;
        repeat (3) tick();
        man_valid = 1'b0;
        man_ready = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("late_fills", fill_cnt - b_fill, 0);
        check_eq("late_fw1", fw1, 32'd0);
        check_eq("late_stall", {31'b0, stall}, 32'd0);
        check_eq("late_req", {31'b0, mem_bus.mem_req_o}, 32'd0);

        // Normal refill after the abandoned one.
        mode = MODE_SAME;
        pat_hi = 16'h6666;
        start_miss(32'h0000_01C4, t0);
        wait_fill("recover", t0, 5);
        check_fill("recover", 32'h1C0, 32'h6666_01C0, 32'h6666_01C4, 32'h6666_01C8, 32'h6666_01CC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
